uart_tx_queue: RTL and testbench
================================

Name: uart_tx_queue

Overview:
- Byte FIFO and transmit scheduler between the CPU's transmit value register and the uart_tx serializer.
- CPU control writes one byte per transmit request. The block buffers the bytes and launches them one at a time on uart_tx using the i_Tx_DV / o_Tx_Done handshake.
- Lets the FSM push score/encoder bytes back-to-back without stalling on the 115200-baud line.

Parameters:
- DEPTH, 16, number of byte entries; must be a power of two, minimum 2.
- ADDR_W, 4, log2(DEPTH); pointer width.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  asynchronous, active-low reset.
- wr_en  input  1  push wr_data this cycle.
- wr_data  input  8  byte to queue.
- clr_overflow  input  1  clears the sticky overflow flag.
- tx_active  input  1  from uart_tx o_Tx_Active.
- tx_done  input  1  from uart_tx o_Tx_Done; one-cycle pulse.
- tx_dv  output  1  to uart_tx i_Tx_DV; one-cycle start strobe.
- tx_byte  output  8  to uart_tx i_Tx_Byte.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- count  output  ADDR_W+1  entries currently held; excludes the byte in flight.
- overflow  output  1  sticky; set when a push is dropped.
- busy  output  1  high whenever the scheduler is not in IDLE.

Behaviour:
- Reset (rst low, asynchronous):
  - Pointers and count go to 0; empty=1, full=0, overflow=0.
  - tx_dv=0, tx_byte=8'h00, busy=0; state=IDLE.
  - Reset mid-transmission abandons the in-flight byte. Queue contents are lost. Any tx_done arriving after release is ignored because state is IDLE.
- Storage: DEPTH x 8 register array, write pointer wp, read pointer rp, ADDR_W bits each.
  - Pointers wrap modulo DEPTH with natural overflow.
  - count is tracked separately, so full vs empty is unambiguous.
- Push: wr_en=1 and (not full, or a pop occurs in the same cycle) -> mem[wp]<=wr_data, wp++.
- Pop: happens only on the IDLE->START transition. tx_byte<=mem[rp], rp++.
- count update: push-only +1; pop-only -1; push and pop together: unchanged.
- Full boundary: push when full with no same-cycle pop is dropped and sets overflow. Pointers and count are unchanged.
- Overflow flag: clr_overflow clears it. If a set and a clear occur in the same cycle, set wins.
- Empty boundary: push into an empty queue is stored normally. The block never pops when empty, so no underflow is possible.
- Scheduler FSM, all outputs registered:
  - IDLE: if not empty and tx_active=0 -> START, performing the pop. Otherwise stay.
  - START: tx_dv=1 for exactly this one cycle; tx_byte holds the popped byte -> WAIT.
  - WAIT: tx_dv=0. On tx_done=1 -> GAP. tx_byte is held stable through the whole state.
  - GAP: one idle cycle, so uart_tx returns to its idle state -> IDLE.
- Latency: a byte pushed into an empty queue while in IDLE with tx_active=0 raises tx_dv 2 cycles after the wr_en edge. Cycle 1: count=1, IDLE sees not empty. Cycle 2: START.
- Back-to-back bytes: the next tx_dv follows tx_done by 3 cycles (GAP, IDLE, START).
- tx_done seen in IDLE, START or GAP is ignored. tx_active high in IDLE blocks launch.
- busy = state != IDLE.

Test Plan:
- Reset: hold rst=0 with random inputs -> empty=1, count=0, tx_dv=0, tx_byte=00, overflow=0. Release; still idle with no pushes.
- Single byte: push 8'hA5 with tx_active=0 -> tx_dv pulses exactly once, 2 cycles later, tx_byte=A5, count returns 0. tx_byte stays A5 until a model tx_done after 100 cycles; busy drops 2 cycles after done.
- Ordering and wrap: push 8'h00..8'h13 (20 bytes, DEPTH=16) while the model UART is slow. The first 17 accepted are 16 stored plus 1 in flight; overflow=1; serial model receives 00..10 in order. Then push 2 more bytes after draining; the pointer wrap still yields FIFO order.
- Full with simultaneous pop: fill to 16 and assert wr_en on the IDLE->START cycle -> byte accepted, count stays 16, overflow stays 0.
- Overflow precedence: cause a drop in the same cycle as clr_overflow=1 -> overflow=1 next cycle. Clear alone next cycle -> 0.
- Reset mid-operation: assert rst during WAIT with 5 bytes queued -> all outputs return to reset values immediately. A later tx_done pulse produces no tx_dv, and count stays 0.

Source files
------------

// File: rtl/uart_tx_queue.sv
// uart_tx_queue: byte FIFO plus transmit scheduler in front of the uart_tx serializer.
// The CPU pushes bytes at full speed. The scheduler launches one byte at a time using the
// tx_dv / tx_done handshake, so the 115200-baud line never stalls the writer.
//
// Ports:
//   clk          system clock; all state changes on the rising edge
//   rst          asynchronous reset, active low
//   wr_en        push wr_data this cycle
//   wr_data      byte to queue
//   clr_overflow clears the sticky overflow flag; a same-cycle drop takes precedence
//   tx_active    serializer busy (uart_tx o_Tx_Active); blocks launches while high
//   tx_done      serializer finished a byte (one-cycle pulse)
//   tx_dv        one-cycle start strobe to uart_tx
//   tx_byte      byte presented to uart_tx; held stable until the next launch
//   full/empty   count == DEPTH / count == 0
//   count        entries held in the queue, not counting the byte in flight
//   overflow     sticky; set when a push is dropped
//   busy         scheduler is not idle
module uart_tx_queue #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [7:0]        wr_data,
    input  logic              clr_overflow,
    input  logic              tx_active,
    input  logic              tx_done,
    output logic              tx_dv,
    output logic [7:0]        tx_byte,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              busy
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StStart = 2'd1;
    localparam logic [1:0] StWait  = 2'd2;
    localparam logic [1:0] StGap   = 2'd3;

    localparam logic [ADDR_W:0] DepthCount = (ADDR_W + 1)'(DEPTH);

    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wp_q, wp_d;
    logic [ADDR_W-1:0] rp_q, rp_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [1:0]        state_q, state_d;
    logic              tx_dv_q, tx_dv_d;
    logic [7:0]        tx_byte_q, tx_byte_d;
    logic              overflow_q, overflow_d;

    logic pop;
    logic push;
    logic drop;

    assign full  = (count_q == DepthCount);
    assign empty = (count_q == '0);

    // Pops happen only on the IDLE->START transition, so an empty queue is never read.
    assign pop  = (state_q == StIdle) && !empty && !tx_active;
    // A full queue still accepts a push when the same cycle frees a slot.
    assign push = wr_en && (!full || pop);
    assign drop = wr_en && full && !pop;

    always_comb begin
        wp_d       = wp_q;
        rp_d       = rp_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        if (push) begin
            wp_d = wp_q + 1'b1;
        end
        if (pop) begin
            rp_d = rp_q + 1'b1;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (drop) begin
            overflow_d = 1'b1;
        end else if (clr_overflow) begin
            overflow_d = 1'b0;
        end
    end

    always_comb begin
        state_d   = state_q;
        tx_dv_d   = 1'b0;
        tx_byte_d = tx_byte_q;

        case (state_q)
            StIdle: begin
                if (pop) begin
                    state_d   = StStart;
                    tx_dv_d   = 1'b1;
                    tx_byte_d = mem[rp_q];
                end
            end
            StStart: begin
                state_d = StWait;
            end
            StWait: begin
                if (tx_done) begin
                    state_d = StGap;
                end
            end
            // One idle cycle so uart_tx settles back to its idle state.
            StGap: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp_q       <= '0;
            rp_q       <= '0;
            count_q    <= '0;
            state_q    <= StIdle;
            tx_dv_q    <= 1'b0;
            tx_byte_q  <= 8'h00;
            overflow_q <= 1'b0;
        end else begin
            wp_q       <= wp_d;
            rp_q       <= rp_d;
            count_q    <= count_d;
            state_q    <= state_d;
            tx_dv_q    <= tx_dv_d;
            tx_byte_q  <= tx_byte_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wp_q] <= wr_data;
        end
    end

    assign tx_dv    = tx_dv_q;
    assign tx_byte  = tx_byte_q;
    assign count    = count_q;
    assign overflow = overflow_q;
    assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_uart_tx_queue.sv
// Testbench for uart_tx_queue: directed scenarios plus a randomized phase, every cycle
// compared against a transaction-level model (byte queue + launch/handshake timing rules).
module tb_uart_tx_queue;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              wr_en = 1'b0;
    logic [7:0]        wr_data = 8'h00;
    logic              clr_overflow = 1'b0;
    logic              tx_active = 1'b0;
    logic              tx_done = 1'b0;
    logic              tx_dv;
    logic [7:0]        tx_byte;
    logic              full;
    logic              empty;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic              busy;

    uart_tx_queue #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .clr_overflow (clr_overflow),
        .tx_active    (tx_active),
        .tx_done      (tx_done),
        .tx_dv        (tx_dv),
        .tx_byte      (tx_byte),
        .full         (full),
        .empty        (empty),
        .count        (count),
        .overflow     (overflow),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model.
    logic [7:0] m_q[$];
    bit         m_ovf;
    bit         m_inflight;   // a byte has been launched and its tx_done not yet seen
    bit         m_started;    // the launch strobe cycle, where tx_done does not count
    bit         m_gap;        // the settle cycle after tx_done
    logic [7:0] m_byte;
    bit         m_dv;

    // Serial-side model: answers each tx_dv with tx_done after u_delay cycles.
    bit         auto_uart = 1'b0;
    int         u_cnt = 0;
    int         u_delay = 4;
    logic [7:0] recv[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_ovf      = 1'b0;
        m_inflight = 1'b0;
        m_started  = 1'b0;
        m_gap      = 1'b0;
        m_byte     = 8'h00;
        m_dv       = 1'b0;
    endtask

    task automatic model_step(input bit w, input logic [7:0] d, input bit clr,
                              input bit act, input bit done);
        bit launch;
        int held;
        held   = m_q.size();
        launch = !m_inflight && !m_gap && (held > 0) && !act;
        if (m_inflight) begin
            if (m_started) m_started = 1'b0;
            else if (done) begin
                m_inflight = 1'b0;
                m_gap      = 1'b1;
            end
        end else if (m_gap) begin
            m_gap = 1'b0;
        end else if (launch) begin
            m_inflight = 1'b1;
            m_started  = 1'b1;
            m_byte     = m_q.pop_front();
        end
        m_dv = launch;
        if (w) begin
            if (held < DEPTH || launch) m_q.push_back(d);
            else m_ovf = 1'b1;
        end
        if (clr && !(w && held >= DEPTH && !launch)) m_ovf = 1'b0;
    endtask

    task automatic check_all();
        chk("tx_dv", tx_dv, m_dv);
        chk("tx_byte", tx_byte, m_byte);
        chk("count", count, m_q.size());
        chk("full", full, m_q.size() == DEPTH);
        chk("empty", empty, m_q.size() == 0);
        chk("overflow", overflow, m_ovf);
        chk("busy", busy, m_inflight || m_gap);
    endtask

    task automatic step(input bit w, input logic [7:0] d, input bit clr,
                        input bit act, input bit done);
        bit a;
        bit dn;
        a  = act;
        dn = done;
        if (auto_uart) begin
            dn = (u_cnt == 1);
            a  = (u_cnt > 1);
        end
        wr_en        = w;
        wr_data      = d;
        clr_overflow = clr;
        tx_active    = a;
        tx_done      = dn;
        @(posedge clk);
        if (!rst) model_reset();
        else model_step(w, d, clr, a, dn);
        #1;
        wr_en        = 1'b0;
        clr_overflow = 1'b0;
        tx_done      = 1'b0;
        if (auto_uart) begin
            if (u_cnt > 0) u_cnt--;
            if (tx_dv) begin
                u_cnt = u_delay;
                recv.push_back(tx_byte);
            end
        end
        check_all();
    endtask

    task automatic drain(input int delay);
        int n;
        auto_uart = 1'b1;
        u_delay   = delay;
        n = 0;
        while ((m_q.size() > 0 || m_inflight || m_gap) && n < 3000) begin
            if (m_inflight && !m_started && u_cnt == 0) u_cnt = 2;
            step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
            n++;
        end
        chk("drain_idle", {30'd0, busy, !empty}, 32'd0);
        auto_uart = 1'b0;
        u_cnt     = 0;
    endtask

    initial begin
        model_reset();

        // Reset held with random inputs.
        for (int i = 0; i < 5; i++) begin
            step(1'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        end
        rst = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        // Single byte with a manually timed tx_done.
        step(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
        chk("single_no_dv_yet", tx_dv, 0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("single_dv", tx_dv, 1);
        chk("single_byte", tx_byte, 8'hA5);
        for (int i = 0; i < 100; i++) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("single_hold", tx_byte, 8'hA5);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("single_gap_busy", busy, 1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("single_idle", busy, 0);

        // Ordering with a slow serializer: 16 stored + 1 in flight, 3 dropped.
        recv.delete();
        auto_uart = 1'b1;
        u_delay   = 30;
        for (int i = 0; i < 20; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
        chk("order_ovf", overflow, 1);
        drain(30);
        chk("order_len", recv.size(), 17);
        for (int i = 0; i < recv.size(); i++) chk("order_byte", recv[i], i);
        recv.delete();
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        auto_uart = 1'b1;
        step(1'b1, 8'hE1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hE2, 1'b0, 1'b0, 1'b0);
        drain(5);
        chk("wrap_len", recv.size(), 2);
        if (recv.size() == 2) begin
            chk("wrap_b0", recv[0], 8'hE1);
            chk("wrap_b1", recv[1], 8'hE2);
        end

        // Fill to 16 while tx_active blocks launch; overflow precedence; push on the pop cycle.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b1, 1'b0);
        chk("fill_count", count, DEPTH);
        step(1'b1, 8'hFF, 1'b1, 1'b1, 1'b0);
        chk("prec_set_wins", overflow, 1);
        step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        chk("prec_clear", overflow, 0);
        step(1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
        chk("full_pop_dv", tx_dv, 1);
        chk("full_pop_count", count, DEPTH);
        chk("full_pop_ovf", overflow, 0);
        drain(3);

        // Reset during WAIT with 5 bytes queued.
        for (int i = 0; i < 6; i++) step(1'b1, 8'(8'h90 + i), 1'b0, 1'b0, 1'b0);
        chk("mid_count", count, 5);
        chk("mid_busy", busy, 1);
        rst = 1'b0;
        #1;
        model_reset();
        chk("rst_dv", tx_dv, 0);
        chk("rst_byte", tx_byte, 0);
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_busy", busy, 0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
            chk("post_rst_dv", tx_dv, 0);
        end

        // Randomized phase.
        for (int i = 0; i < 800; i++) begin
            step($urandom_range(1, 0) == 1, 8'($urandom), $urandom_range(7, 0) == 0,
                 $urandom_range(3, 0) == 0, $urandom_range(5, 0) == 0);
        end
        drain(6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
